// File: rtl/a5_keystream_engine.sv
// A5/1-style keystream engine: three majority-clocked LFSRs load key and frame,
// warm up, then XOR a CHUNKLEN-bit keystream burst onto a valid/ready bit stream.
module a5_keystream_engine #(
  parameter int unsigned          REG1LEN     = 19,
  parameter int unsigned          REG2LEN     = 22,
  parameter int unsigned          REG3LEN     = 23,
  parameter logic [REG1LEN-1:0]   MASK1       = 19'h72000,
  parameter logic [REG2LEN-1:0]   MASK2       = 22'h300000,
  parameter logic [REG3LEN-1:0]   MASK3       = 23'h700080,
  parameter int unsigned          SYNCBIT1    = 8,
  parameter int unsigned          SYNCBIT2    = 10,
  parameter int unsigned          SYNCBIT3    = 10,
  parameter int unsigned          KEYLEN      = 64,
  parameter int unsigned          FRAMENUMLEN = 22,
  parameter int unsigned          MIXLEN      = 100,
  parameter int unsigned          CHUNKLEN    = 114
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [KEYLEN-1:0]      key,
  input  logic [FRAMENUMLEN-1:0] frame,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   abort,
  input  logic                   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAMENUMLEN-1:0] frame_cur
);

  localparam int unsigned MAX_KF = (KEYLEN > FRAMENUMLEN) ? KEYLEN : FRAMENUMLEN;
  localparam int unsigned MAX_MC = (MIXLEN > CHUNKLEN) ? MIXLEN : CHUNKLEN;
  localparam int unsigned MAXLEN = (MAX_KF > MAX_MC) ? MAX_KF : MAX_MC;
  localparam int unsigned CNTW   = $clog2(MAXLEN) + 1;
  localparam int unsigned KIDXW  = (KEYLEN > 1) ? $clog2(KEYLEN) : 1;
  localparam int unsigned FIDXW  = (FRAMENUMLEN > 1) ? $clog2(FRAMENUMLEN) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_FRAME,
    MIX,
    STREAM
  } state_t;

  state_t              state;
  logic [CNTW-1:0]     cnt;
  logic [KEYLEN-1:0]   key_q;
  logic [REG1LEN-1:0]  r1_q;
  logic [REG2LEN-1:0]  r2_q;
  logic [REG3LEN-1:0]  r3_q;

  logic                fb1;
  logic                fb2;
  logic                fb3;
  logic                maj;
  logic                load_bit;
  logic                ks_bit;
  logic                xfer;
  logic                phase_last;
  logic [REG1LEN-1:0]  r1_maj;
  logic [REG2LEN-1:0]  r2_maj;
  logic [REG3LEN-1:0]  r3_maj;

  // Abort blocks the input handshake in the same cycle it is raised.
  assign in_ready = (state == STREAM) && !abort && (!out_valid || out_ready);
  assign busy     = (state != IDLE);

  // Feedback, majority-clocked next values and the keystream bit they produce.
  always_comb begin
    fb1      = ^(r1_q & MASK1);
    fb2      = ^(r2_q & MASK2);
    fb3      = ^(r3_q & MASK3);
    maj      = (r1_q[SYNCBIT1] & r2_q[SYNCBIT2]) |
               (r1_q[SYNCBIT1] & r3_q[SYNCBIT3]) |
               (r2_q[SYNCBIT2] & r3_q[SYNCBIT3]);
    r1_maj   = (r1_q[SYNCBIT1] == maj) ? {r1_q[REG1LEN-2:0], fb1} : r1_q;
    r2_maj   = (r2_q[SYNCBIT2] == maj) ? {r2_q[REG2LEN-2:0], fb2} : r2_q;
    r3_maj   = (r3_q[SYNCBIT3] == maj) ? {r3_q[REG3LEN-2:0], fb3} : r3_q;
    ks_bit   = r1_maj[REG1LEN-1] ^ r2_maj[REG2LEN-1] ^ r3_maj[REG3LEN-1];
    load_bit = (state == LOAD_KEY) ? key_q[KIDXW'(cnt)] : frame_cur[FIDXW'(cnt)];
    xfer     = in_valid && in_ready;
    case (state)
      LOAD_KEY:   phase_last = (cnt == CNTW'(KEYLEN - 1));
      LOAD_FRAME: phase_last = (cnt == CNTW'(FRAMENUMLEN - 1));
      MIX:        phase_last = (cnt == CNTW'(MIXLEN - 1));
      STREAM:     phase_last = (cnt == CNTW'(CHUNKLEN - 1));
      default:    phase_last = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      key_q      <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      r3_q       <= '0;
      frame_cur  <= '0;
      out_data   <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_q     <= key;
            frame_cur <= frame;
            r1_q      <= '0;
            r2_q      <= '0;
            r3_q      <= '0;
            cnt       <= '0;
            state     <= LOAD_KEY;
          end
        end
        // Key and frame bits are folded into bit 0 after an unconditional step.
        LOAD_KEY, LOAD_FRAME: begin
          r1_q <= {r1_q[REG1LEN-2:0], fb1 ^ load_bit};
          r2_q <= {r2_q[REG2LEN-2:0], fb2 ^ load_bit};
          r3_q <= {r3_q[REG3LEN-2:0], fb3 ^ load_bit};
          if (phase_last) begin
            cnt   <= '0;
            state <= (state == LOAD_KEY) ? LOAD_FRAME : MIX;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        MIX: begin
          r1_q <= r1_maj;
          r2_q <= r2_maj;
          r3_q <= r3_maj;
          if (phase_last) begin
            cnt   <= '0;
            state <= STREAM;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        // Registers only advance on an accepted input bit, so stalls are lossless.
        STREAM: begin
          if (xfer) begin
            out_data  <= in_data ^ ks_bit;
            out_valid <= 1'b1;
            if (phase_last) begin
              frame_done <= 1'b1;
              cnt        <= '0;
              if (continuous) begin
                frame_cur <= frame_cur + FRAMENUMLEN'(1);
                r1_q      <= '0;
                r2_q      <= '0;
                r3_q      <= '0;
                state     <= LOAD_KEY;
              end else begin
                r1_q  <= r1_maj;
                r2_q  <= r2_maj;
                r3_q  <= r3_maj;
                state <= IDLE;
              end
            end else begin
              r1_q <= r1_maj;
              r2_q <= r2_maj;
              r3_q <= r3_maj;
              cnt  <= cnt + CNTW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a5_keystream_engine.sv
// Bench for a5_keystream_engine: directed frames checked against a bit-level
// A5/1 reference model through an output scoreboard.
module tb_a5_keystream_engine;

  localparam int unsigned CH = 114;
  localparam logic [63:0] GKEY = 64'h1223456789ABCDEF;

  logic        clock;
  logic        reset;
  logic [63:0] key;
  logic [21:0] frame;
  logic        start;
  logic        continuous;
  logic        abort;
  logic        in_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        frame_done;
  logic [21:0] frame_cur;

  int checks = 0;
  int failures = 0;
  int stall_mode = 0;
  int data_mode = 0;

  logic          exp_q[$];
  logic [CH-1:0] burst_q[$];
  logic [CH-1:0] cur_ks = '0;
  int idx = 0;
  int xfers = 0;
  int fd_count = 0;
  int cyc = 0;
  int last_xfer_cyc = -1;
  int last_gap = -1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  a5_keystream_engine dut (
    .clock      (clock),
    .reset      (reset),
    .key        (key),
    .frame      (frame),
    .start      (start),
    .continuous (continuous),
    .abort      (abort),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cur  (frame_cur)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference keystream: bit i of the result is the i-th keystream bit of the burst.
  function automatic logic [CH-1:0] a5_ks(input logic [63:0] k, input logic [21:0] f);
    logic [18:0]   a;
    logic [21:0]   b;
    logic [22:0]   c;
    logic [85:0]   ld;
    logic [CH-1:0] ks;
    logic          inb;
    logic          m;
    int            s;
    a  = '0;
    b  = '0;
    c  = '0;
    ks = '0;
    ld = {f, k};
    for (int i = 0; i < 86; i++) begin
      inb = ld[0];
      ld  = ld >> 1;
      a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13] ^ inb};
      b = {b[20:0], b[21] ^ b[20] ^ inb};
      c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7] ^ inb};
    end
    for (int i = 0; i < 100 + int'(CH); i++) begin
      s = int'(a[8]) + int'(b[10]) + int'(c[10]);
      m = (s >= 2);
      if (a[8] == m)  a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13]};
      if (b[10] == m) b = {b[20:0], b[21] ^ b[20]};
      if (c[10] == m) c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7]};
      if (i >= 100) ks = {a[18] ^ b[21] ^ c[22], ks[CH-1:1]};
    end
    return ks;
  endfunction

  // Scoreboard: expected outputs are queued at input transfer, checked at output acceptance.
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      exp_q.delete();
      burst_q.delete();
      idx = 0;
      last_xfer_cyc = -1;
    end else begin
      if (frame_done) fd_count++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected actual=%0b required=no output", out_data);
        end else begin
          chk("out_data", 128'(out_data), 128'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        if (idx == 0 && burst_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL xfer_unexpected actual=in_ready=1 required=no burst pending");
        end else begin
          if (idx == 0) begin
            cur_ks = burst_q.pop_front();
            if (last_xfer_cyc >= 0) last_gap = cyc - last_xfer_cyc - 1;
          end
          exp_q.push_back(in_data ^ cur_ks[0]);
          cur_ks = cur_ks >> 1;
          idx++;
          xfers++;
          last_xfer_cyc = cyc;
          if (idx == int'(CH)) idx = 0;
        end
      end
      if (abort) begin
        exp_q.delete();
        burst_q.delete();
        idx = 0;
      end
    end
  end

  // Background data and downstream-ready drivers.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      in_data   = (data_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = (stall_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame(input logic [63:0] k, input logic [21:0] f, input logic cont);
    key        = k;
    frame      = f;
    continuous = cont;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk("frame_cur_latch", 128'(frame_cur), 128'(f));
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((busy || out_valid) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_done_in_time"}, 128'(n < 3000), 128'(1));
    tick();
  endtask

  task automatic wait_xfers(input int target, output int got);
    int t;
    got = 0;
    t   = 0;
    while (got < target && t < 2000) begin
      @(negedge clock);
      t++;
      if (in_valid && in_ready) got++;
    end
  endtask

  task automatic run_frame(input string nm, input logic [63:0] k, input logic [21:0] f,
                           input int stall, input int dmode, input bit check_lat);
    int fd0;
    int x0;
    int lat;
    stall_mode = stall;
    data_mode  = dmode;
    in_valid   = 1'b1;
    burst_q.push_back(a5_ks(k, f));
    fd0 = fd_count;
    x0  = xfers;
    start_frame(k, f, 1'b0);
    if (check_lat) begin
      lat = 0;
      do begin
        @(negedge clock);
        lat++;
      end while (!in_ready && lat < 1000);
      chk({nm, "_latency"}, 128'(lat), 128'(187));
    end
    wait_done(nm);
    chk({nm, "_frame_done_count"}, 128'(fd_count - fd0), 128'(1));
    chk({nm, "_bits"}, 128'(xfers - x0), 128'(CH));
    chk({nm, "_busy_after"}, 128'(busy), 128'(0));
  endtask

  initial begin
    int n;
    int fd0;
    int x0;
    int bad;
    reset = 1'b0; key = '0; frame = '0; start = 1'b0; continuous = 1'b0;
    abort = 1'b0; in_data = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_frame_done", 128'(frame_done), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_frame_cur", 128'(frame_cur), 128'(0));
    reset = 1'b1;
    tick();
    tick();
    chk("idle_in_ready", 128'(in_ready), 128'(0));

    // Model pins: all-zero inputs keep every register zero; one key bit changes the burst.
    chk("model_zero_key", 128'(a5_ks(64'h0, 22'h0)), 128'(0));
    chk("model_key_sensitive", 128'(a5_ks(GKEY, 22'h134) != a5_ks(GKEY ^ 64'h1, 22'h134)), 128'(1));
    chk("model_frame_sensitive", 128'(a5_ks(GKEY, 22'h134) != a5_ks(GKEY, 22'h135)), 128'(1));

    run_frame("zero_key", 64'h0, 22'h0, 0, 1, 1'b1);
    run_frame("golden", GKEY, 22'h134, 0, 0, 1'b0);
    run_frame("key_bit0", 64'h1, 22'h134, 0, 0, 1'b0);
    run_frame("frame_max", GKEY, 22'h3FFFFF, 0, 0, 1'b0);
    run_frame("backpressure", GKEY, 22'h134, 1, 1, 1'b0);

    // Continuous: frame number wraps to 0 for the second burst.
    stall_mode = 0;
    data_mode  = 1;
    fd0 = fd_count;
    x0  = xfers;
    burst_q.push_back(a5_ks(GKEY, 22'h3FFFFF));
    burst_q.push_back(a5_ks(GKEY, 22'h0));
    start_frame(GKEY, 22'h3FFFFF, 1'b1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_done && n < 1000);
    chk("cont_frame_done_seen", 128'(frame_done), 128'(1));
    chk("cont_frame_wrap", 128'(frame_cur), 128'(0));
    chk("cont_busy_between", 128'(busy), 128'(1));
    tick();
    continuous = 1'b0;
    wait_done("cont");
    chk("cont_frame_done_count", 128'(fd_count - fd0), 128'(2));
    chk("cont_bits", 128'(xfers - x0), 128'(2 * CH));
    chk("cont_gap", 128'(last_gap), 128'(186));
    chk("cont_frame_cur_end", 128'(frame_cur), 128'(0));

    // Abort while bit 50 is being offered.
    fd0 = fd_count;
    x0  = xfers;
    burst_q.push_back(a5_ks(GKEY, 22'h134));
    start_frame(GKEY, 22'h134, 1'b0);
    wait_xfers(50, n);
    chk("abort_reach_bit50", 128'(n), 128'(50));
    @(posedge clock);
    #1;
    abort = 1'b1;
    #1;
    chk("abort_in_ready", 128'(in_ready), 128'(0));
    tick();
    abort = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    repeat (150) tick();
    chk("abort_no_frame_done", 128'(fd_count - fd0), 128'(0));
    chk("abort_bits", 128'(xfers - x0), 128'(50));

    // start while busy is ignored; latched key and frame stay in use.
    fd0 = fd_count;
    burst_q.push_back(a5_ks(GKEY, 22'h134));
    start_frame(GKEY, 22'h134, 1'b0);
    repeat (100) tick();
    key   = 64'h0;
    frame = 22'h5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_frame_cur", 128'(frame_cur), 128'(22'h134));
    wait_done("busy_start");
    chk("busy_start_frame_done", 128'(fd_count - fd0), 128'(1));
    chk("busy_start_frame_cur_end", 128'(frame_cur), 128'(22'h134));

    // Asynchronous reset in the middle of a burst.
    burst_q.push_back(a5_ks(GKEY, 22'h134));
    start_frame(GKEY, 22'h134, 1'b0);
    wait_xfers(20, n);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_out_data", 128'(out_data), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
    chk("mid_rst_frame_cur", 128'(frame_cur), 128'(0));
    chk("mid_rst_frame_done", 128'(frame_done), 128'(0));
    repeat (3) tick();
    reset = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (in_ready || busy) bad++;
    end
    chk("post_rst_idle", 128'(bad), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
